// File: rtl/gauss3x3_mem_engine.sv
// gauss3x3_mem_engine: raster-fetches an image over the read port,
// applies a 3x3 Gaussian and writes interior results back by address.
module gauss3x3_mem_engine #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              finish
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = ADDR_W - CW;
    localparam int SW = DATA_W + 4;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W-1:0] OFS  = ADDR_W'(IMG_W + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t state_q, state_d;
    logic   drain_q;

    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];
    logic [DATA_W-1:0] win [3][3];

    logic              win_valid_q;
    logic [ADDR_W-1:0] win_addr_q;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic              sample;
    logic              win_done;
    logic [SW-1:0]     sum;
    logic [SW-1:0]     rnd;
    logic [DATA_W-1:0] result;

    assign col      = in_addr[CW-1:0];
    assign row      = in_addr[ADDR_W-1:CW];
    assign sample   = (state_q == FETCH) && in_valid;
    assign win_done = sample && (row >= RW'(2)) && (col >= CW'(2));

    // Next-state logic; dropping in_valid aborts any active phase
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) state_d = FETCH;
            end
            FETCH: begin
                if (!in_valid)            state_d = IDLE;
                else if (in_addr == LAST) state_d = DRAIN;
            end
            DRAIN: begin
                if (!in_valid)   state_d = IDLE;
                else if (drain_q) state_d = DONE;
            end
            DONE: begin
                if (!in_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Kernel 1 2 1 / 2 4 2 / 1 2 1 with round-half-up divide by 16
    always_comb begin
        sum = SW'(win[0][0]) + SW'(win[0][2])
            + SW'(win[2][0]) + SW'(win[2][2])
            + (SW'(win[0][1]) << 1) + (SW'(win[1][0]) << 1)
            + (SW'(win[1][2]) << 1) + (SW'(win[2][1]) << 1)
            + (SW'(win[1][1]) << 2);
        rnd    = sum + SW'(8);
        result = rnd[SW-1:4];
    end

    // Line buffers: lb1 holds row r-1, lb2 holds row r-2 at each column
    always_ff @(posedge clk) begin
        if (sample) begin
            lb1[col] <= in_data;
            lb2[col] <= lb1[col];
        end
    end

    // Window shifts left one column per sampled pixel
    always_ff @(posedge clk) begin
        if (sample) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= lb2[col];
            win[1][2] <= lb1[col];
            win[2][2] <= in_data;
        end
    end

    // Window-complete flag and centre address, aligned with the window
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid_q <= 1'b0;
            win_addr_q  <= '0;
        end else begin
            win_valid_q <= win_done;
            win_addr_q  <= in_addr - OFS;
        end
    end

    // State, fetch address and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            drain_q   <= 1'b0;
            in_addr   <= '0;
            finish    <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            state_q   <= state_d;
            drain_q   <= (state_q == DRAIN) && (state_d == DRAIN);
            finish    <= (state_d == DONE);
            out_valid <= win_valid_q && in_valid;
            if (win_valid_q) begin
                out_addr <= win_addr_q;
                out_data <= result;
            end
            if (state_d == IDLE)
                in_addr <= '0;
            else if (sample && in_addr != LAST)
                in_addr <= in_addr + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_gauss3x3_mem_engine.sv
// tb_gauss3x3_mem_engine: image memory model, reference convolution
// scoreboard, abort/reset sequences and spot-value table.
module tb_gauss3x3_mem_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_addr;
    logic [7:0]  in_data;
    logic        out_valid;
    logic [15:0] out_addr;
    logic [7:0]  out_data;
    logic        finish;

    typedef struct {
        int     addr;
        int     data;
        longint due;
    } exp_t;

    typedef struct {
        int r;
        int c;
        int exp;
    } vec_t;

    exp_t   sb[$];
    vec_t   vecs[15];
    int     wr_cnt[65536];
    int     wr_data[65536];
    int     total_wr = 0;
    int     first_wr_addr = -1;
    longint first_wr_cyc = -1;
    longint t514 = -1;
    longint cyc = 0;
    int     checks = 0;
    int     failures = 0;

    gauss3x3_mem_engine dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_addr (out_addr),
        .out_data (out_data),
        .finish   (finish)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Image: constant band, ramp band, impulse band, hashed band
    function automatic logic [7:0] pix(input logic [15:0] a);
        int r;
        int c;
        r = int'(a[15:8]);
        c = int'(a[7:0]);
        if (r < 64)  return 8'd100;
        if (r < 120) return 8'(c);
        if (r < 140) return (r == 128 && c == 128) ? 8'd255 : 8'd0;
        return 8'(((r * 7 + c * 13) ^ (r * c)) & 255);
    endfunction

    function automatic int ref_out(input int r, input int c);
        int s;
        int w;
        s = 0;
        for (int i = -1; i <= 1; i++) begin
            for (int j = -1; j <= 1; j++) begin
                w = ((i == 0) ? 2 : 1) * ((j == 0) ? 2 : 1);
                s += w * int'(pix(16'(((r + i) << 8) + (c + j))));
            end
        end
        return (s + 8) / 16;
    endfunction

    assign in_data = pix(in_addr);

    task automatic check(input string name, input longint act,
                         input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Output monitor: pops scoreboard on every write
    always @(negedge clk) begin
        exp_t e;
        check("valid_and_finish", 64'(out_valid && finish), 0);
        if (out_valid) begin
            wr_cnt[out_addr]++;
            wr_data[out_addr] = int'(out_data);
            total_wr++;
            if (total_wr == 1) begin
                first_wr_addr = int'(out_addr);
                first_wr_cyc  = cyc;
            end
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=addr %0d required=no write",
                         out_addr);
            end else begin
                e = sb.pop_front();
                check("sb_addr", out_addr, e.addr);
                check("sb_data", out_data, e.data);
                check("sb_latency", cyc, e.due);
            end
        end
    end

    // Starts a run and follows it until in_addr reaches last
    task automatic run_fetch(input int last, input bit push_last);
        int r;
        int c;
        in_valid = 1'b1;
        for (int idx = 0; idx <= last; idx++) begin
            step();
            check("in_addr_seq", in_addr, idx);
            if (idx == 514) t514 = cyc;
            r = idx >> 8;
            c = idx & 255;
            if (r >= 2 && c >= 2 && (idx != last || push_last))
                sb.push_back('{idx - 257, ref_out(r - 1, c - 1), cyc + 2});
        end
    endtask

    initial begin
        longint s;
        longint fcyc;
        int     bad;
        int     r;
        int     c;

        vecs[0]  = '{128, 128, 64};
        vecs[1]  = '{127, 128, 32};
        vecs[2]  = '{129, 128, 32};
        vecs[3]  = '{128, 127, 32};
        vecs[4]  = '{128, 129, 32};
        vecs[5]  = '{127, 127, 16};
        vecs[6]  = '{127, 129, 16};
        vecs[7]  = '{129, 127, 16};
        vecs[8]  = '{129, 129, 16};
        vecs[9]  = '{130, 128, 0};
        vecs[10] = '{1, 1, 100};
        vecs[11] = '{62, 254, 100};
        vecs[12] = '{100, 77, 77};
        vecs[13] = '{65, 1, 1};
        vecs[14] = '{100, 254, 254};

        rst = 1'b1;
        in_valid = 1'b0;
        repeat (3) step();
        check("rst_in_addr", in_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_finish", finish, 0);
        rst = 1'b0;
        repeat (3) step();
        check("idle_in_addr", in_addr, 0);

        // Abort by dropping in_valid mid-fetch
        run_fetch(1000, 1'b0);
        in_valid = 1'b0;
        sb.delete();
        step();
        check("abort_out_valid", out_valid, 0);
        check("abort_in_addr", in_addr, 0);
        repeat (5) begin
            step();
            check("abort_finish", finish, 0);
            check("abort_idle_addr", in_addr, 0);
        end

        // Synchronous reset mid-fetch
        run_fetch(3000, 1'b0);
        rst = 1'b1;
        sb.delete();
        step();
        check("midrst_in_addr", in_addr, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_addr", out_addr, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_finish", finish, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (2) step();
        check("midrst_idle_addr", in_addr, 0);

        // Full run after reset with stale line buffers
        for (int i = 0; i < 65536; i++) begin
            wr_cnt[i] = 0;
            wr_data[i] = -1;
        end
        total_wr = 0;
        s = cyc;
        run_fetch(65535, 1'b1);
        fcyc = -1;
        for (int i = 0; i < 10 && fcyc < 0; i++) begin
            step();
            if (finish) fcyc = cyc;
        end
        check("finish_cycle", (fcyc < 0) ? -1 : fcyc - s, 65539);
        check("first_write_addr", first_wr_addr, 257);
        check("first_write_latency", first_wr_cyc - t514, 2);
        repeat (3) begin
            step();
            check("done_out_valid", out_valid, 0);
            check("done_finish", finish, 1);
        end
        check("sb_leftover", sb.size(), 0);
        check("total_writes", total_wr, 64516);

        in_valid = 1'b0;
        step();
        check("drop_finish", finish, 0);
        check("drop_in_addr", in_addr, 0);
        step();
        check("idle_finish", finish, 0);

        bad = 0;
        for (int a = 0; a < 65536; a++) begin
            r = a >> 8;
            c = a & 255;
            if (r == 0 || r == 255 || c == 0 || c == 255) begin
                if (wr_cnt[a] != 0) bad++;
            end else if (wr_cnt[a] != 1) begin
                bad++;
            end
        end
        check("write_coverage_anomalies", bad, 0);

        for (int i = 0; i < 15; i++) begin
            check($sformatf("vec_r%0d_c%0d", vecs[i].r, vecs[i].c),
                  wr_data[vecs[i].r * 256 + vecs[i].c], vecs[i].exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
